// File: rtl/filtro_pkg.sv
// Shared definitions for the multichannel biquad IIR filter.
//  - estado_e : FSM states, one per cycle of the 7-cycle computation.
//  - dato_e   : data operand select for the shared multiplier.
//  - COEF_*   : coefficient register indices (Coef_Sel encoding).
//  - trunc_wrap / trunc_sat : accumulator -> sample reduction (floor shift by frac, then
//    two's-complement wrap or saturation to n bits). Operate on a wide fixed type; callers
//    sign-extend into it and slice the low n bits of the result.
package filtro_pkg;

  typedef enum logic [2:0] {StIdle, StA1, StA2, StB0, StB1, StB2, StOut} estado_e;

  typedef enum logic [1:0] {DatF1, DatF2, DatF} dato_e;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  localparam int unsigned NUM_COEF = 5;

  localparam int unsigned TRUNC_W = 128;
  typedef logic signed [TRUNC_W-1:0] ancho_t;

  // Floor shift, then keep the low n bits re-sign-extended.
  function automatic ancho_t trunc_wrap(input ancho_t acc, input int unsigned n,
                                        input int unsigned frac);
    ancho_t s;
    s = acc >>> frac;
    return (s <<< (TRUNC_W - n)) >>> (TRUNC_W - n);
  endfunction

  // Floor shift, then clamp to [-2^(n-1), 2^(n-1)-1].
  function automatic ancho_t trunc_sat(input ancho_t acc, input int unsigned n,
                                       input int unsigned frac);
    ancho_t s, hi, lo, r;
    s  = acc >>> frac;
    hi = (ancho_t'(1) <<< (n - 1)) - ancho_t'(1);
    lo = -hi - ancho_t'(1);
    if (s > hi)      r = hi;
    else if (s < lo) r = lo;
    else             r = s;
    return r;
  endfunction

endpackage

// File: rtl/filtro_mac_nucleo.sv
// Shared multiply-accumulate core of the biquad filter.
//  clk_i, rst_i       : clock, synchronous active-high reset (clears the accumulator)
//  coef_i, coef_sel_i : coefficient bank and selected coefficient (sel >= 5 gives zero)
//  f1_i, f2_i, f_i    : candidate data operands; dat_sel_i picks one
//  load_i/load_val_i  : overwrite accumulator with load_val_i (highest priority)
//  clear_i            : use zero instead of the accumulator as the add/sub base
//  add_i / sub_i      : acc <= base +/- coef*data
//  acc_o              : accumulator, 2N+3 bits so three 2N-bit products never overflow
module filtro_mac_nucleo
  import filtro_pkg::*;
#(
  parameter int unsigned N     = 25,
  parameter int unsigned ACC_W = 2 * N + 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [N-1:0]     coef_i [NUM_COEF],
  input  logic [2:0]              coef_sel_i,
  input  logic signed [N-1:0]     f1_i,
  input  logic signed [N-1:0]     f2_i,
  input  logic signed [N-1:0]     f_i,
  input  dato_e                   dat_sel_i,
  input  logic                    load_i,
  input  logic signed [ACC_W-1:0] load_val_i,
  input  logic                    clear_i,
  input  logic                    add_i,
  input  logic                    sub_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [N-1:0]     op_coef, op_dat;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext, base, acc_d, acc_q;

  always_comb begin
    op_coef = '0;
    if (32'(coef_sel_i) < NUM_COEF) op_coef = coef_i[coef_sel_i];
    unique case (dat_sel_i)
      DatF1:   op_dat = f1_i;
      DatF2:   op_dat = f2_i;
      DatF:    op_dat = f_i;
      default: op_dat = '0;
    endcase
  end

  assign prod     = op_coef * op_dat;
  assign prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};
  assign base     = clear_i ? '0 : acc_q;

  always_comb begin
    acc_d = acc_q;
    if (load_i)       acc_d = load_val_i;
    else if (add_i)   acc_d = base + prod_ext;
    else if (sub_i)   acc_d = base - prod_ext;
    else if (clear_i) acc_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/filtro_iir_biquad_multicanal.sv
// Time-multiplexed direct-form-II biquad low-pass filter for CH ADC channels.
// One shared MAC; per-channel f[k-1]/f[k-2] banks; run-time writable coefficients.
//  Clk, Reset (sync, active-high)
//  Uk, Canal, Bandera_ADC        : input sample, its channel, 1-cycle strobe
//  Coef_We, Coef_Sel, Coef_Dato  : coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored)
//  Yk, Canal_Yk, Bandera_Listo   : result, its channel, 1-cycle valid pulse
//  Ocupado                       : FSM not idle
//  Muestra_Perdida               : 1-cycle pulse when a strobe is dropped (busy or bad channel)
// Build option: define FILTRO_SATURACION_EN to saturate f and Yk instead of wrapping.
module filtro_iir_biquad_multicanal
  import filtro_pkg::*;
#(
  parameter  int unsigned N    = 25,
  parameter  int unsigned FRAC = 20,
  parameter  int unsigned CH   = 2,
  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic signed [N-1:0] Uk,
  input  logic [CH_W-1:0]     Canal,
  input  logic                Bandera_ADC,
  input  logic                Coef_We,
  input  logic [2:0]          Coef_Sel,
  input  logic signed [N-1:0] Coef_Dato,
  output logic signed [N-1:0] Yk,
  output logic [CH_W-1:0]     Canal_Yk,
  output logic                Bandera_Listo,
  output logic                Ocupado,
  output logic                Muestra_Perdida
);

  localparam int unsigned ACC_W = 2 * N + 3;

  estado_e                 state_q, state_d;
  logic [CH_W-1:0]         ch_q, canal_yk_q;
  logic signed [N-1:0]     f1_q [CH];
  logic signed [N-1:0]     f2_q [CH];
  logic signed [N-1:0]     coef_q [NUM_COEF];
  logic signed [N-1:0]     f_q, f_d, yk_q;
  logic                    listo_q, perdida_q, perdida_d, acepta;
  logic                    mac_load, mac_clear, mac_add, mac_sub;
  logic [2:0]              coef_sel;
  dato_e                   dat_sel;
  logic signed [ACC_W-1:0] acc, load_val;
  ancho_t                  acc_ext;

  // f during S_B0 and Yk during S_OUT both come from this single reduction of acc.
  assign acc_ext  = ancho_t'(acc);
`ifdef FILTRO_SATURACION_EN
  assign f_d = N'(trunc_sat(acc_ext, N, FRAC));
`else
  assign f_d = N'(trunc_wrap(acc_ext, N, FRAC));
`endif
  assign load_val = {{(ACC_W - N){Uk[N-1]}}, Uk} <<< FRAC;

  always_comb begin
    state_d   = state_q;
    acepta    = 1'b0;
    perdida_d = 1'b0;
    mac_load  = 1'b0;
    mac_clear = 1'b0;
    mac_add   = 1'b0;
    mac_sub   = 1'b0;
    coef_sel  = COEF_B0;
    dat_sel   = DatF1;
    unique case (state_q)
      StIdle: begin
        if (Bandera_ADC) begin
          if (32'(Canal) < CH) begin
            acepta   = 1'b1;
            mac_load = 1'b1;
            state_d  = StA1;
          end else begin
            perdida_d = 1'b1;
          end
        end
      end
      StA1: begin mac_sub = 1'b1; coef_sel = COEF_A1; dat_sel = DatF1; state_d = StA2; end
      StA2: begin mac_sub = 1'b1; coef_sel = COEF_A2; dat_sel = DatF2; state_d = StB0; end
      StB0: begin
        // acc = b0*f, with f taken combinationally from the current accumulator
        mac_clear = 1'b1;
        mac_add   = 1'b1;
        coef_sel  = COEF_B0;
        dat_sel   = DatF;
        state_d   = StB1;
      end
      StB1: begin mac_add = 1'b1; coef_sel = COEF_B1; dat_sel = DatF1; state_d = StB2; end
      StB2: begin mac_add = 1'b1; coef_sel = COEF_B2; dat_sel = DatF2; state_d = StOut; end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (Bandera_ADC && state_q != StIdle) perdida_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      f_q        <= '0;
      yk_q       <= '0;
      canal_yk_q <= '0;
      listo_q    <= 1'b0;
      perdida_q  <= 1'b0;
      f1_q       <= '{default: '0};
      f2_q       <= '{default: '0};
      coef_q     <= '{default: '0};
      coef_q[COEF_B0] <= {{(N - FRAC - 1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    end else begin
      state_q   <= state_d;
      perdida_q <= perdida_d;
      listo_q   <= (state_q == StOut);
      if (acepta) ch_q <= Canal;
      if (state_q == StB0) f_q <= f_d;
      if (state_q == StOut) begin
        yk_q       <= f_d;
        canal_yk_q <= ch_q;
        f2_q[ch_q] <= f1_q[ch_q];
        f1_q[ch_q] <= f_q;
      end
      if (Coef_We && 32'(Coef_Sel) < NUM_COEF) coef_q[Coef_Sel] <= Coef_Dato;
    end
  end

  filtro_mac_nucleo #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .coef_i     (coef_q),
    .coef_sel_i (coef_sel),
    .f1_i       (f1_q[ch_q]),
    .f2_i       (f2_q[ch_q]),
    .f_i        (f_d),
    .dat_sel_i  (dat_sel),
    .load_i     (mac_load),
    .load_val_i (load_val),
    .clear_i    (mac_clear),
    .add_i      (mac_add),
    .sub_i      (mac_sub),
    .acc_o      (acc)
  );

  assign Yk              = yk_q;
  assign Canal_Yk        = canal_yk_q;
  assign Bandera_Listo   = listo_q;
  assign Ocupado         = (state_q != StIdle);
  assign Muestra_Perdida = perdida_q;

endmodule
